// File: rtl/sorting_pkg.sv
`default_nettype none
// ============================================================================
// sorting_pkg -- sizing helpers and compare-exchange rule for the kv sorter.
// Rev 1.0
// ============================================================================
package sorting_pkg;

  localparam int KEY_MAX_W = 64;

  function automatic int stages_f(input int n, input int lps);
    return (n + lps - 1) / lps;
  endfunction

  function automatic int idx_width_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Strict compares only: equal keys never swap, which keeps the sort stable.
  function automatic logic swap_f(input logic [KEY_MAX_W-1:0] key_a,
                                  input logic [KEY_MAX_W-1:0] key_b,
                                  input logic                 descend);
    return descend ? (key_a < key_b) : (key_a > key_b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kv_sorting_network_if.sv
`default_nettype none
// ============================================================================
// kv_sorting_network_if -- vector in/out bus with valid/ready for the sorter.
// Rev 1.0
// ============================================================================
interface kv_sorting_network_if #(
  parameter int NUMBER_WIDTH   = 10,
  parameter int TAG_WIDTH      = 8,
  parameter int NUMBERS_AMOUNT = 10
);
  import sorting_pkg::*;

  localparam int IDX_W = idx_width_f(NUMBERS_AMOUNT);

  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i;
  logic [NUMBERS_AMOUNT-1:0][TAG_WIDTH-1:0]    tag_i;
  logic                                        descend_i;
  logic                                        data_valid_i;
  logic                                        data_ready_o;

  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_o;
  logic [NUMBERS_AMOUNT-1:0][TAG_WIDTH-1:0]    tag_o;
  logic [NUMBERS_AMOUNT-1:0][IDX_W-1:0]        index_o;
  logic                                        descend_o;
  logic                                        data_valid_o;
  logic                                        data_ready_i;

  modport slave (
    input  data_i, tag_i, descend_i, data_valid_i, data_ready_i,
    output data_ready_o, data_o, tag_o, index_o, descend_o, data_valid_o
  );

  modport master (
    output data_i, tag_i, descend_i, data_valid_i, data_ready_i,
    input  data_ready_o, data_o, tag_o, index_o, descend_o, data_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/sort_layer.sv
`default_nettype none
// ============================================================================
// sort_layer -- one combinational odd/even transposition layer over records.
// Rev 1.0
// ============================================================================
module sort_layer
  import sorting_pkg::*;
#(
  parameter  int NUMBER_WIDTH   = 10,
  parameter  int TAG_WIDTH      = 8,
  parameter  int NUMBERS_AMOUNT = 10,
  parameter  int PARITY         = 0,
  localparam int IDX_W          = idx_width_f(NUMBERS_AMOUNT),
  localparam int REC_W          = NUMBER_WIDTH + TAG_WIDTH + IDX_W
) (
  input  logic [NUMBERS_AMOUNT-1:0][REC_W-1:0] i_recs,
  input  logic                                 i_descend,
  output logic [NUMBERS_AMOUNT-1:0][REC_W-1:0] o_recs
);

  typedef struct packed {
    logic [NUMBER_WIDTH-1:0] key;
    logic [TAG_WIDTH-1:0]    tag;
    logic [IDX_W-1:0]        idx;
  } rec_t;

  rec_t [NUMBERS_AMOUNT-1:0] w_in;
  rec_t [NUMBERS_AMOUNT-1:0] w_out;

  assign w_in   = i_recs;
  assign o_recs = w_out;

  // Unpaired edge elements fall out of the default copy untouched.
  always_comb begin
    w_out = w_in;
    for (int i = PARITY; i + 1 < NUMBERS_AMOUNT; i += 2) begin
      if (swap_f(KEY_MAX_W'(w_in[i].key), KEY_MAX_W'(w_in[i+1].key), i_descend)) begin
        w_out[i]   = w_in[i+1];
        w_out[i+1] = w_in[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/kv_sorting_network.sv
`default_nettype none
// ============================================================================
// kv_sorting_network -- pipelined stable key/tag sorter with global stall.
// Rev 1.0
// ============================================================================
module kv_sorting_network
  import sorting_pkg::*;
#(
  parameter int NUMBER_WIDTH     = 10,
  parameter int TAG_WIDTH        = 8,
  parameter int NUMBERS_AMOUNT   = 10,
  parameter int LAYERS_PER_STAGE = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  kv_sorting_network_if.slave bus
);

  localparam int N      = NUMBERS_AMOUNT;
  localparam int LPS    = LAYERS_PER_STAGE;
  localparam int IDX_W  = idx_width_f(N);
  localparam int STAGES = stages_f(N, LPS);

  typedef struct packed {
    logic [NUMBER_WIDTH-1:0] key;
    logic [TAG_WIDTH-1:0]    tag;
    logic [IDX_W-1:0]        idx;
  } rec_t;

  typedef rec_t [N-1:0] vec_t;

  function automatic int stage_last_f(input int s);
    return ((((s + 1) * LPS) < N) ? ((s + 1) * LPS) : N) - 1;
  endfunction

  vec_t r_recs  [STAGES];
  logic r_desc  [STAGES];
  logic r_valid [STAGES];

  vec_t w_entry;
  vec_t w_stage_out  [STAGES];
  logic w_stage_desc [STAGES];
  logic w_stage_vld  [STAGES];
  logic w_en;

  // Ready depends combinationally on the consumer's ready.
  assign w_en             = bus.data_ready_i | ~r_valid[STAGES-1];
  assign bus.data_ready_o = w_en;

  always_comb begin
    w_entry = '0;
    for (int i = 0; i < N; i++) begin
      w_entry[i].key = bus.data_i[i];
      w_entry[i].tag = bus.tag_i[i];
      w_entry[i].idx = IDX_W'(i);
    end
  end

  genvar gs;
  genvar gl;

  for (gs = 0; gs < STAGES; gs++) begin : g_stage_in
    if (gs == 0) begin : g_head
      assign w_stage_desc[gs] = bus.descend_i;
      assign w_stage_vld[gs]  = bus.data_valid_i & w_en;
    end else begin : g_tail
      assign w_stage_desc[gs] = r_desc[gs-1];
      assign w_stage_vld[gs]  = r_valid[gs-1];
    end
  end

  for (gl = 0; gl < N; gl++) begin : g_layer
    vec_t w_lin;
    vec_t w_lout;

    if (gl == 0) begin : g_src_input
      assign w_lin = w_entry;
    end else if ((gl % LPS) == 0) begin : g_src_reg
      assign w_lin = r_recs[(gl / LPS) - 1];
    end else begin : g_src_chain
      assign w_lin = g_layer[gl-1].w_lout;
    end

    sort_layer #(
      .NUMBER_WIDTH   (NUMBER_WIDTH),
      .TAG_WIDTH      (TAG_WIDTH),
      .NUMBERS_AMOUNT (N),
      .PARITY         (gl % 2)
    ) u_layer (
      .i_recs    (w_lin),
      .i_descend (w_stage_desc[gl / LPS]),
      .o_recs    (w_lout)
    );

    if (gl == stage_last_f(gl / LPS)) begin : g_stage_end
      assign w_stage_out[gl / LPS] = w_lout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        r_recs[s]  <= '0;
        r_desc[s]  <= 1'b0;
        r_valid[s] <= 1'b0;
      end
    end else if (w_en) begin
      for (int s = 0; s < STAGES; s++) begin
        r_recs[s]  <= w_stage_out[s];
        r_desc[s]  <= w_stage_desc[s];
        r_valid[s] <= w_stage_vld[s];
      end
    end
  end

  always_comb begin
    bus.data_o  = '0;
    bus.tag_o   = '0;
    bus.index_o = '0;
    for (int i = 0; i < N; i++) begin
      bus.data_o[i]  = r_recs[STAGES-1][i].key;
      bus.tag_o[i]   = r_recs[STAGES-1][i].tag;
      bus.index_o[i] = r_recs[STAGES-1][i].idx;
    end
  end

  assign bus.descend_o    = r_desc[STAGES-1];
  assign bus.data_valid_o = r_valid[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_kv_sorting_network.sv
`default_nettype none
// ============================================================================
// tb_kv_sorting_network -- directed and scoreboarded checks, N=4/LPS=1 and N=5/LPS=2.
// Rev 1.0
// ============================================================================
module tb_kv_sorting_network;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  kv_sorting_network_if #(.NUMBER_WIDTH(10), .TAG_WIDTH(8), .NUMBERS_AMOUNT(4)) b4 ();
  kv_sorting_network_if #(.NUMBER_WIDTH(10), .TAG_WIDTH(8), .NUMBERS_AMOUNT(5)) b5 ();

  kv_sorting_network #(
    .NUMBER_WIDTH(10), .TAG_WIDTH(8), .NUMBERS_AMOUNT(4), .LAYERS_PER_STAGE(1)
  ) u4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));

  kv_sorting_network #(
    .NUMBER_WIDTH(10), .TAG_WIDTH(8), .NUMBERS_AMOUNT(5), .LAYERS_PER_STAGE(2)
  ) u5 (.clk_i(clk), .rst_i(rst), .bus(b5.slave));

  typedef struct packed {
    logic [127:0] k;
    logic [127:0] t;
    logic [127:0] i;
    logic         d;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] k4(input int a0, a1, a2, a3);
    return 128'({10'(a3), 10'(a2), 10'(a1), 10'(a0)});
  endfunction
  function automatic logic [127:0] t4(input int a0, a1, a2, a3);
    return 128'({8'(a3), 8'(a2), 8'(a1), 8'(a0)});
  endfunction
  function automatic logic [127:0] i4(input int a0, a1, a2, a3);
    return 128'({2'(a3), 2'(a2), 2'(a1), 2'(a0)});
  endfunction
  function automatic logic [127:0] k5(input int a0, a1, a2, a3, a4);
    return 128'({10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)});
  endfunction
  function automatic logic [127:0] i5(input int a0, a1, a2, a3, a4);
    return 128'({3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)});
  endfunction

  // Stable insertion sort: returns the original positions in output order.
  function automatic void ref_sort(input int n, input bit desc, input int key[8],
                                   output int oidx[8]);
    int t;
    for (int i = 0; i < 8; i++) oidx[i] = i;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (key[oidx[j]] > key[oidx[j-1]]) : (key[oidx[j]] < key[oidx[j-1]])) begin
          t         = oidx[j];
          oidx[j]   = oidx[j-1];
          oidx[j-1] = t;
        end else begin
          break;
        end
      end
    end
  endfunction

  function automatic exp_t mk_exp(input int n, input bit desc, input int key[8], input int tag[8]);
    exp_t e;
    int   oi[8];
    int   iw;
    e  = '0;
    iw = (n == 4) ? 2 : 3;
    ref_sort(n, desc, key, oi);
    for (int j = 0; j < n; j++) begin
      e.k[j*10 +: 10] = 10'(key[oi[j]]);
      e.t[j*8 +: 8]   = 8'(tag[oi[j]]);
      for (int b = 0; b < iw; b++) e.i[j*iw + b] = oi[j][b];
    end
    e.d = desc;
    return e;
  endfunction

  task automatic drive4(input int a0, a1, a2, a3, input bit desc);
    b4.data_i[0] = 10'(a0); b4.data_i[1] = 10'(a1);
    b4.data_i[2] = 10'(a2); b4.data_i[3] = 10'(a3);
    b4.tag_i[0]  = 8'h0A;   b4.tag_i[1]  = 8'h0B;
    b4.tag_i[2]  = 8'h0C;   b4.tag_i[3]  = 8'h0D;
    b4.descend_i    = desc;
    b4.data_valid_i = 1'b1;
  endtask

  task automatic set4(input int kk[8], input int tt[8], input bit desc);
    for (int i = 0; i < 4; i++) begin
      b4.data_i[i] = 10'(kk[i]);
      b4.tag_i[i]  = 8'(tt[i]);
    end
    b4.descend_i = desc;
  endtask

  task automatic set5(input int kk[8], input int tt[8], input bit desc);
    for (int i = 0; i < 5; i++) begin
      b5.data_i[i] = 10'(kk[i]);
      b5.tag_i[i]  = 8'(tt[i]);
    end
    b5.descend_i = desc;
  endtask

  initial begin
    int           kk[8];
    int           tt[8];
    bit           dd;
    exp_t         e;
    int           sent;
    int           got;
    int           seen;
    bit           need_new;
    bit           held;
    logic [127:0] hk;
    logic [127:0] hi;
    logic [3:0]   pat;

    for (int i = 0; i < 8; i++) begin kk[i] = 0; tt[i] = 0; end
    rst = 1'b1;
    b4.data_i = '0; b4.tag_i = '0; b4.descend_i = 1'b0; b4.data_valid_i = 1'b0; b4.data_ready_i = 1'b1;
    b5.data_i = '0; b5.tag_i = '0; b5.descend_i = 1'b0; b5.data_valid_i = 1'b0; b5.data_ready_i = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_data",  128'(b4.data_o), 128'(0));
    chk("rst_meta",  128'({b4.tag_o, b4.index_o, b4.descend_o, b4.data_valid_o}), 128'(0));
    chk("rst_ready", 128'(b4.data_ready_o), 128'(1));
    chk("rst_valid5", 128'(b5.data_valid_o), 128'(0));

    // ascending then descending, back to back
    drive4(3, 1, 2, 0, 1'b0);
    step();
    drive4(3, 1, 2, 0, 1'b1);
    step();
    b4.data_valid_i = 1'b0;
    step();
    chk("asc_early", 128'(b4.data_valid_o), 128'(0));
    step();
    chk("asc_valid", 128'(b4.data_valid_o), 128'(1));
    chk("asc_key",   128'(b4.data_o),  k4(0, 1, 2, 3));
    chk("asc_idx",   128'(b4.index_o), i4(3, 1, 2, 0));
    chk("asc_tag",   128'(b4.tag_o),   t4(8'h0D, 8'h0B, 8'h0C, 8'h0A));
    chk("asc_desc",  128'(b4.descend_o), 128'(0));
    step();
    chk("dsc_valid", 128'(b4.data_valid_o), 128'(1));
    chk("dsc_key",   128'(b4.data_o),  k4(3, 2, 1, 0));
    chk("dsc_idx",   128'(b4.index_o), i4(0, 2, 1, 3));
    chk("dsc_tag",   128'(b4.tag_o),   t4(8'h0A, 8'h0C, 8'h0B, 8'h0D));
    chk("dsc_desc",  128'(b4.descend_o), 128'(1));
    step();
    chk("dsc_gone",  128'(b4.data_valid_o), 128'(0));

    // stability with equal keys
    drive4(5, 5, 1, 5, 1'b0);
    step();
    drive4(5, 5, 1, 5, 1'b1);
    step();
    b4.data_valid_i = 1'b0;
    step();
    step();
    chk("stab_asc_key", 128'(b4.data_o),  k4(1, 5, 5, 5));
    chk("stab_asc_idx", 128'(b4.index_o), i4(2, 0, 1, 3));
    step();
    chk("stab_dsc_key", 128'(b4.data_o),  k4(5, 5, 5, 1));
    chk("stab_dsc_idx", 128'(b4.index_o), i4(0, 1, 3, 2));

    // odd N with two layers per stage
    for (int i = 0; i < 5; i++) b5.tag_i[i] = 8'(i + 1);
    b5.data_i[0] = 10'd9; b5.data_i[1] = 10'd7; b5.data_i[2] = 10'd8;
    b5.data_i[3] = 10'd0; b5.data_i[4] = 10'd3;
    b5.descend_i    = 1'b0;
    b5.data_valid_i = 1'b1;
    step();
    b5.data_valid_i = 1'b0;
    step();
    chk("odd_early", 128'(b5.data_valid_o), 128'(0));
    step();
    chk("odd_valid", 128'(b5.data_valid_o), 128'(1));
    chk("odd_key",   128'(b5.data_o),  k5(0, 3, 7, 8, 9));
    chk("odd_idx",   128'(b5.index_o), i5(3, 4, 1, 2, 0));
    step();

    // random stream against the stable reference sort
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 1100 && (sent < 1000 || q5.size() > 0); cyc++) begin
      if (b5.data_valid_o) begin
        if (q5.size() > 0) e = q5.pop_front();
        else e = '0;
        got++;
        chk("rnd_key",  128'(b5.data_o),    e.k);
        chk("rnd_idx",  128'(b5.index_o),   e.i);
        chk("rnd_tag",  128'(b5.tag_o),     e.t);
        chk("rnd_desc", 128'(b5.descend_o), 128'(e.d));
      end
      if (sent < 1000) begin
        for (int i = 0; i < 5; i++) begin
          kk[i] = int'($urandom_range(0, ((sent % 3) == 0) ? 1023 : 3));
          tt[i] = int'($urandom_range(0, 255));
        end
        dd = bit'($urandom_range(0, 1));
        set5(kk, tt, dd);
        b5.data_valid_i = 1'b1;
        q5.push_back(mk_exp(5, dd, kk, tt));
        sent++;
      end else begin
        b5.data_valid_i = 1'b0;
      end
      step();
    end
    b5.data_valid_i = 1'b0;
    chk("rnd_count", 128'(got), 128'(1000));
    chk("rnd_drain", 128'(q5.size()), 128'(0));

    // backpressure: consumer ready cycles 1,0,0,1
    pat      = 4'b1001;
    sent     = 0;
    got      = 0;
    need_new = 1'b1;
    held     = 1'b0;
    hk       = '0;
    hi       = '0;
    for (int cyc = 0; cyc < 100 && (sent < 12 || q4.size() > 0); cyc++) begin
      if (sent < 12 && need_new) begin
        for (int i = 0; i < 4; i++) begin
          kk[i] = int'($urandom_range(0, 7));
          tt[i] = int'($urandom_range(0, 255));
        end
        dd = bit'($urandom_range(0, 1));
        set4(kk, tt, dd);
        need_new = 1'b0;
      end
      b4.data_valid_i = (sent < 12);
      b4.data_ready_i = pat[cyc % 4];
      #1;
      chk("bp_ready", 128'(b4.data_ready_o), 128'(!(b4.data_valid_o && !b4.data_ready_i)));
      if (held) begin
        chk("bp_hold_key", 128'(b4.data_o),  hk);
        chk("bp_hold_idx", 128'(b4.index_o), hi);
      end
      if (b4.data_valid_o) begin
        if (b4.data_ready_i) begin
          if (q4.size() > 0) e = q4.pop_front();
          else e = '0;
          got++;
          chk("bp_key",  128'(b4.data_o),    e.k);
          chk("bp_idx",  128'(b4.index_o),   e.i);
          chk("bp_tag",  128'(b4.tag_o),     e.t);
          chk("bp_desc", 128'(b4.descend_o), 128'(e.d));
          held = 1'b0;
        end else begin
          held = 1'b1;
          hk   = 128'(b4.data_o);
          hi   = 128'(b4.index_o);
        end
      end else begin
        held = 1'b0;
      end
      if (b4.data_valid_i && b4.data_ready_o) begin
        q4.push_back(mk_exp(4, dd, kk, tt));
        sent++;
        need_new = 1'b1;
      end
      step();
    end
    b4.data_valid_i = 1'b0;
    b4.data_ready_i = 1'b1;
    chk("bp_count", 128'(got), 128'(12));
    chk("bp_drain", 128'(q4.size()), 128'(0));
    step();
    step();
    step();
    step();

    // reset with three vectors in flight
    drive4(1, 2, 3, 0, 1'b0);
    step();
    drive4(2, 0, 1, 3, 1'b1);
    step();
    drive4(0, 3, 2, 1, 1'b0);
    step();
    b4.data_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_data",  128'(b4.data_o), 128'(0));
    chk("rstmid_meta",  128'({b4.tag_o, b4.index_o, b4.descend_o, b4.data_valid_o}), 128'(0));
    chk("rstmid_ready", 128'(b4.data_ready_o), 128'(1));
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (b4.data_valid_o) seen++;
    end
    chk("rstmid_dropped", 128'(seen), 128'(0));
    drive4(2, 3, 0, 1, 1'b0);
    step();
    b4.data_valid_i = 1'b0;
    step();
    step();
    chk("rstmid_early", 128'(b4.data_valid_o), 128'(0));
    step();
    chk("rstmid_valid", 128'(b4.data_valid_o), 128'(1));
    chk("rstmid_key",   128'(b4.data_o),  k4(0, 1, 2, 3));
    chk("rstmid_idx",   128'(b4.index_o), i4(2, 3, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
